load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: bus cycles allowed per access before abort.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 mem_read_i  input  1  MEM-stage load request.
REQ-005 mem_write_i  input  1  MEM-stage store request; never asserted together with mem_read_i.
REQ-006 addr_i  input  32  byte address (EX/MEM ALU result).
REQ-007 wdata_i  input  32  store data, right-justified.
REQ-008 byte_size_i  input  2  access size: 00 byte, 01 half, 10 word (11 treated as word).
REQ-009 sign_ext_i  input  1  1 = sign-extend load result, 0 = zero-extend.
REQ-010 rdata_o  output  32  aligned, extended load data, valid in DONE.
REQ-011 stall_o  output  1  freeze all stages IF through MEM.
REQ-012 misalign_o  output  1  one-cycle pulse: misaligned access rejected.
REQ-013 err_o  output  1  one-cycle pulse: bus error or timeout.
REQ-014 bus_req_o  output  1  bus request valid.
REQ-015 bus_we_o  output  1  1 = write.
REQ-016 bus_addr_o  output  32  word-aligned address ({addr_i[31:2],2'b00}).
REQ-017 bus_wdata_o  output  32  lane-replicated store data.
REQ-018 bus_wstrb_o  output  4  byte write strobes; 0000 on reads.
REQ-019 bus_ready_i  input  1  request accepted when bus_req_o && bus_ready_i.
REQ-020 bus_rvalid_i  input  1  read data valid.
REQ-021 bus_rdata_i  input  32  read data word.
REQ-022 bus_err_i  input  1  error response, sampled with bus_ready_i (writes) or bus_rvalid_i (reads).

Function
REQ-023 FSM states IDLE, REQ, RESP, DONE; one access in flight at most.
REQ-024 IDLE: aligned mem_read_i|mem_write_i -> REQ next edge; stall_o asserted combinationally in that same IDLE cycle.
REQ-025 Misaligned (half with addr_i[0]=1; word with addr_i[1:0]!=0): no bus request, misalign_o=1 for that cycle, stall_o=0, rdata_o=0, stay IDLE.
REQ-026 REQ: bus_req_o=1, all bus outputs held stable until handshake; write handshake -> DONE; read handshake -> RESP.
REQ-027 RESP: bus_rvalid_i captures bus_rdata_i -> DONE; rvalid in same cycle as ready is not accepted (RESP always at least one cycle).
REQ-028 DONE: one cycle, stall_o=0, rdata_o valid; next state IDLE unconditionally (the pipeline advances, so the same access is never reissued).
REQ-029 stall_o=1 in REQ and RESP, 0 in DONE and IDLE except per REQ-024.
REQ-030 Store lanes: byte -> wdata_i[7:0] replicated x4, strobe 4'b0001<<addr_i[1:0]; half -> wdata_i[15:0] x2, strobe 0011 (addr_i[1]=0) or 1100; word -> 1111.
REQ-031 Load extraction: byte lane = addr_i[1:0], half lane = addr_i[1]; bit 7/15 extended per sign_ext_i; word unchanged.
REQ-032 8-bit cycle counter cleared on IDLE->REQ, increments in REQ/RESP; reaching TIMEOUT_CYCLES -> DONE, err_o=1, rdata_o=0.
REQ-033 bus_err_i at handshake or rvalid -> DONE, err_o=1, rdata_o=0.
REQ-034 err_o and misalign_o never asserted together.

Reset
REQ-035 reset asserted (any state, including mid-access) -> IDLE, counter 0, all outputs 0 in the same cycle; an outstanding bus response arriving after reset release is ignored.

Verification
REQ-036 LW addr 0x100, ready after 2 cycles, rvalid with 0xDEADBEEF 3 cycles later -> stall high 6 cycles, DONE rdata_o=0xDEADBEEF.
REQ-037 LB addr 0x103, sign_ext=1, bus word 0x80112233 -> rdata_o=0xFFFFFF80; LBU -> 0x00000080.
REQ-038 SH addr 0x202, wdata 0x0000ABCD, ready immediate -> bus_wdata_o=0xABCDABCD, wstrb=1100, bus_addr_o=0x200, stall 2 cycles.
REQ-039 LW addr 0x101 -> misalign_o pulse, bus_req_o never asserted, stall_o=0.
REQ-040 TIMEOUT_CYCLES=4, bus_ready_i held 0 -> err_o pulse after 4 counted cycles, FSM IDLE next cycle.
REQ-041 reset pulsed while in RESP, stale rvalid 2 cycles later -> ignored, outputs 0, next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit bridging the pipeline to a single-outstanding request/response bus.
// Stores are lane-replicated with byte strobes; loads are lane-extracted and sign/zero-extended.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  byte_size_i,
  input  logic        sign_ext_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  input  logic        bus_ready_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  // state | meaning
  // IDLE  | waiting for a MEM-stage access; misaligned ones are rejected here
  // REQ   | request presented on the bus, held stable until bus_ready_i
  // RESP  | read accepted, waiting for bus_rvalid_i
  // DONE  | single completion cycle; the pipeline advances past the access
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_RESP = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        access_c;
  logic        misaligned_c;
  logic [31:0] lane_wdata_c;
  logic [3:0]  lane_wstrb_c;
  logic [7:0]  cnt_inc_c;
  logic        timeout_c;
  logic        stall_c;
  logic        misalign_c;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  offset,
                                               input logic [1:0]  size,
                                               input logic        sign_ext);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v = word[{offset, 3'b000} +: 8];
    half_v = offset[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   load_extract = {{24{sign_ext & byte_v[7]}}, byte_v};
      2'b01:   load_extract = {{16{sign_ext & half_v[15]}}, half_v};
      default: load_extract = word;
    endcase
  endfunction

  assign access_c  = mem_read_i | mem_write_i;
  assign cnt_inc_c = cnt_q + 8'd1;
  assign timeout_c = (cnt_inc_c == TIMEOUT_LIMIT);

  // Size 2'b11 falls into the word branch.
  always_comb begin
    lane_wdata_c = wdata_i;
    lane_wstrb_c = 4'b1111;
    misaligned_c = 1'b0;
    case (byte_size_i)
      2'b00: begin
        lane_wdata_c = {4{wdata_i[7:0]}};
        lane_wstrb_c = 4'b0001 << addr_i[1:0];
      end
      2'b01: begin
        lane_wdata_c = {2{wdata_i[15:0]}};
        lane_wstrb_c = addr_i[1] ? 4'b1100 : 4'b0011;
        misaligned_c = addr_i[0];
      end
      default: misaligned_c = (addr_i[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    we_d       = we_q;
    size_d     = size_q;
    sign_d     = sign_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    stall_c    = 1'b0;
    misalign_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (access_c) begin
          if (misaligned_c) begin
            misalign_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = S_REQ;
            addr_d  = addr_i;
            we_d    = mem_write_i;
            wdata_d = mem_write_i ? lane_wdata_c : 32'h0;
            wstrb_d = mem_write_i ? lane_wstrb_c : 4'b0000;
            size_d  = byte_size_i;
            sign_d  = sign_ext_i;
            rdata_d = 32'h0;
            cnt_d   = 8'h0;
          end
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        cnt_d   = cnt_inc_c;
        // A handshake in the same cycle as the terminal count still completes normally.
        if (bus_ready_i) begin
          if (we_q) begin
            state_d = S_DONE;
            err_d   = bus_err_i;
          end else begin
            state_d = S_RESP;
          end
        end else if (timeout_c) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_RESP: begin
        stall_c = 1'b1;
        cnt_d   = cnt_inc_c;
        if (bus_rvalid_i) begin
          state_d = S_DONE;
          err_d   = bus_err_i;
          rdata_d = bus_err_i ? 32'h0 : load_extract(bus_rdata_i, addr_q[1:0], size_q, sign_q);
        end else if (timeout_c) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'b0000;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // IDLE-cycle outputs follow the request inputs, so reset must gate them directly.
  assign stall_o     = stall_c & ~reset;
  assign misalign_o  = misalign_c & ~reset;
  assign err_o       = (state_q == S_DONE) & err_q;
  assign rdata_o     = ((state_q == S_DONE) && !err_q) ? rdata_q : 32'h0;
  assign bus_req_o   = (state_q == S_REQ);
  assign bus_we_o    = bus_req_o & we_q;
  assign bus_addr_o  = bus_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_wdata_o = bus_req_o ? wdata_q : 32'h0;
  assign bus_wstrb_o = bus_req_o ? wstrb_q : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expectations, a monitor and a
// bus responder compare DUT behaviour; a second instance with TIMEOUT_CYCLES=4 covers abort.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_read_i, mem_write_i;
  logic [31:0] addr_i, wdata_i;
  logic [1:0]  byte_size_i;
  logic        sign_ext_i;
  logic [31:0] rdata_o;
  logic        stall_o, misalign_o, err_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_wstrb_o;
  logic        bus_ready_i, bus_rvalid_i, bus_err_i;
  logic [31:0] bus_rdata_i;

  logic        t_read;
  logic [31:0] t_rdata, t_addr, t_wdata;
  logic        t_stall, t_mis, t_err, t_req, t_we;
  logic [3:0]  t_wstrb;

  always #5 clock = ~clock;

  load_store_unit dut (
    .clock(clock), .reset(reset),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .byte_size_i(byte_size_i), .sign_ext_i(sign_ext_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .misalign_o(misalign_o), .err_o(err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_ready_i(bus_ready_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clock(clock), .reset(reset),
    .mem_read_i(t_read), .mem_write_i(1'b0),
    .addr_i(32'h0000_0700), .wdata_i(32'h0), .byte_size_i(2'b10), .sign_ext_i(1'b0),
    .rdata_o(t_rdata), .stall_o(t_stall), .misalign_o(t_mis), .err_o(t_err),
    .bus_req_o(t_req), .bus_we_o(t_we), .bus_addr_o(t_addr),
    .bus_wdata_o(t_wdata), .bus_wstrb_o(t_wstrb),
    .bus_ready_i(1'b0), .bus_rvalid_i(1'b0),
    .bus_rdata_i(32'h0), .bus_err_i(1'b0)
  );

  typedef struct {
    bit          is_mis;
    logic [31:0] rdata;
    bit          err;
    int          stall;
  } exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_exp_t;

  typedef struct {
    bit rd; bit wr; logic [31:0] a; logic [31:0] wd; logic [1:0] sz; bit sx;
    int rdy; int rvd; logic [31:0] word; bit berr;
    bit mis; logic [31:0] rdata; bit err; int stall;
    logic [31:0] baddr; logic [31:0] bwdata; logic [3:0] wstrb;
  } vec_t;

  exp_t     exp_q[$];
  bus_exp_t bus_q[$];
  vec_t     vecs[$];

  int n_cmp = 0;
  int n_bad = 0;

  int          ready_dly = 0;
  int          rvalid_dly = 1;
  logic [31:0] rsp_data = 32'h0;
  bit          rsp_err = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endfunction

  function automatic void fail_event(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event with nothing expected", name);
  endfunction

  // Bus responder: checks presented requests and answers with the configured latencies.
  initial begin
    int  reqc = 0;
    int  rvc = 0;
    bit  in_resp = 1'b0;
    bus_ready_i  = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_err_i    = 1'b0;
    bus_rdata_i  = 32'h0;
    forever begin
      @(negedge clock);
      bus_ready_i  = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_err_i    = 1'b0;
      bus_rdata_i  = 32'h0;
      if (bus_req_o && bus_q.size() != 0) begin
        check("bus_we", bus_we_o, bus_q[0].we);
        check("bus_addr", bus_addr_o, bus_q[0].addr);
        check("bus_wstrb", bus_wstrb_o, bus_q[0].wstrb);
        if (bus_q[0].we) check("bus_wdata", bus_wdata_o, bus_q[0].wdata);
        reqc++;
        if (reqc > ready_dly) begin
          bus_ready_i = 1'b1;
          bus_err_i   = rsp_err && bus_q[0].we;
          if (!bus_q[0].we) begin
            in_resp = 1'b1;
            rvc     = 0;
          end
          void'(bus_q.pop_front());
        end
      end else begin
        if (bus_q.size() == 0) check("no_bus_req", bus_req_o, 1'b0);
        reqc = 0;
        if (in_resp) begin
          rvc++;
          if (rvc >= rvalid_dly) begin
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = rsp_data;
            bus_err_i    = rsp_err;
            in_resp      = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: pops an expectation on each misalign pulse or completed (DONE) access.
  initial begin
    int   run = 0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        run = 0;
      end else if (misalign_o) begin
        if (exp_q.size() == 0) fail_event("unexpected_misalign");
        else begin
          e = exp_q.pop_front();
          check("mis_kind", misalign_o, e.is_mis);
          check("mis_stall", stall_o, 1'b0);
          check("mis_rdata", rdata_o, 32'h0);
          check("mis_err", err_o, 1'b0);
        end
      end else if (stall_o) begin
        run++;
      end else if (run > 0) begin
        if (exp_q.size() == 0) fail_event("unexpected_done");
        else begin
          e = exp_q.pop_front();
          check("done_kind", misalign_o, e.is_mis);
          check("done_rdata", rdata_o, e.rdata);
          check("done_err", err_o, e.err);
          check("done_stall_cycles", run, e.stall);
        end
        run = 0;
      end
    end
  end

  task automatic do_access(input vec_t v);
    exp_t     e;
    bus_exp_t b;
    int       n;
    @(posedge clock);
    #1;
    ready_dly  = v.rdy;
    rvalid_dly = v.rvd;
    rsp_data   = v.word;
    rsp_err    = v.berr;
    e = '{v.mis, v.rdata, v.err, v.stall};
    exp_q.push_back(e);
    if (!v.mis) begin
      b = '{v.wr, v.baddr, v.bwdata, v.wstrb};
      bus_q.push_back(b);
    end
    mem_read_i  = v.rd;
    mem_write_i = v.wr;
    addr_i      = v.a;
    wdata_i     = v.wd;
    byte_size_i = v.sz;
    sign_ext_i  = v.sx;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (stall_o && n < 200);
    if (stall_o) check("access_bound", stall_o, 1'b0);
    @(posedge clock);
    #1;
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
  endtask

  initial begin
    bus_exp_t b;
    int       n;
    int       nreq;

    reset       = 1'b1;
    mem_read_i  = 1'b1;
    mem_write_i = 1'b0;
    addr_i      = 32'h0000_0100;
    wdata_i     = 32'h0;
    byte_size_i = 2'b10;
    sign_ext_i  = 1'b0;
    t_read      = 1'b0;
    #2;
    check("rst_stall", stall_o, 1'b0);
    check("rst_bus_req", bus_req_o, 1'b0);
    check("rst_misalign", misalign_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_rdata", rdata_o, 32'h0);
    mem_read_i = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b0;

    //         rd    wr    addr           wdata          sz     sx   rdy rvd word           berr  mis   rdata          err   stall baddr          bwdata         wstrb
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0100, 32'h0,         2'b10, 1'b0, 1, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 6, 32'h0000_0100, 32'h0,         4'b0000});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0103, 32'h0,         2'b00, 1'b1, 0, 1, 32'h8011_2233, 1'b0, 1'b0, 32'hFFFF_FF80, 1'b0, 3, 32'h0000_0100, 32'h0,         4'b0000});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0103, 32'h0,         2'b00, 1'b0, 0, 1, 32'h8011_2233, 1'b0, 1'b0, 32'h0000_0080, 1'b0, 3, 32'h0000_0100, 32'h0,         4'b0000});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0202, 32'h0000_ABCD, 2'b01, 1'b0, 0, 0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 2, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0101, 32'h0,         2'b10, 1'b0, 0, 1, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 0, 32'h0,         32'h0,         4'b0000});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0206, 32'h0,         2'b01, 1'b1, 0, 2, 32'h8001_7FFF, 1'b0, 1'b0, 32'hFFFF_8001, 1'b0, 4, 32'h0000_0204, 32'h0,         4'b0000});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0204, 32'h0,         2'b01, 1'b0, 1, 1, 32'h1234_8765, 1'b0, 1'b0, 32'h0000_8765, 1'b0, 4, 32'h0000_0204, 32'h0,         4'b0000});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0201, 32'h0,         2'b00, 1'b1, 0, 1, 32'h1122_7F44, 1'b0, 1'b0, 32'h0000_007F, 1'b0, 3, 32'h0000_0200, 32'h0,         4'b0000});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0301, 32'hFFFF_FF5A, 2'b00, 1'b0, 0, 0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 2, 32'h0000_0300, 32'h5A5A_5A5A, 4'b0010});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0303, 32'h0000_00C3, 2'b00, 1'b0, 0, 0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 2, 32'h0000_0300, 32'hC3C3_C3C3, 4'b1000});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0200, 32'h1234_BEEF, 2'b01, 1'b0, 0, 0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 2, 32'h0000_0200, 32'hBEEF_BEEF, 4'b0011});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0400, 32'h0123_4567, 2'b10, 1'b0, 2, 0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 4, 32'h0000_0400, 32'h0123_4567, 4'b1111});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0404, 32'hAAAA_5555, 2'b10, 1'b0, 0, 0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 2, 32'h0000_0404, 32'hAAAA_5555, 4'b1111});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0408, 32'h0,         2'b10, 1'b0, 0, 1, 32'h1234_5678, 1'b1, 1'b0, 32'h0,         1'b1, 3, 32'h0000_0408, 32'h0,         4'b0000});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0103, 32'h0,         2'b01, 1'b1, 0, 1, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 0, 32'h0,         32'h0,         4'b0000});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0201, 32'h0000_1111, 2'b01, 1'b0, 0, 0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 0, 32'h0,         32'h0,         4'b0000});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0500, 32'h0,         2'b11, 1'b1, 0, 1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0, 3, 32'h0000_0500, 32'h0,         4'b0000});

    foreach (vecs[i]) do_access(vecs[i]);

    // Reset in the middle of a read's response phase; the late rvalid must be ignored.
    ready_dly  = 0;
    rvalid_dly = 4;
    rsp_data   = 32'h5555_AAAA;
    rsp_err    = 1'b0;
    b = '{1'b0, 32'h0000_0600, 32'h0, 4'b0000};
    bus_q.push_back(b);
    @(posedge clock);
    #1;
    mem_read_i  = 1'b1;
    addr_i      = 32'h0000_0600;
    byte_size_i = 2'b10;
    sign_ext_i  = 1'b0;
    repeat (3) @(negedge clock);
    check("pre_reset_stall", stall_o, 1'b1);
    #1;
    reset      = 1'b1;
    mem_read_i = 1'b0;
    #1;
    check("midrst_stall", stall_o, 1'b0);
    check("midrst_bus_req", bus_req_o, 1'b0);
    check("midrst_err", err_o, 1'b0);
    check("midrst_rdata", rdata_o, 32'h0);
    check("midrst_bus_addr", bus_addr_o, 32'h0);
    @(negedge clock);
    #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("stale_stall", stall_o, 1'b0);
      check("stale_err", err_o, 1'b0);
      check("stale_rdata", rdata_o, 32'h0);
      check("stale_bus_req", bus_req_o, 1'b0);
    end
    do_access('{1'b1, 1'b0, 32'h0000_0604, 32'h0, 2'b10, 1'b0, 0, 1, 32'h0BAD_F00D, 1'b0,
                1'b0, 32'h0BAD_F00D, 1'b0, 3, 32'h0000_0604, 32'h0, 4'b0000});

    // Timeout instance: ready never comes, abort after four counted bus cycles.
    @(posedge clock);
    #1;
    t_read = 1'b1;
    n    = 0;
    nreq = 0;
    do begin
      @(negedge clock);
      if (t_stall) n++;
      if (t_req) nreq++;
    end while (t_stall && n < 50);
    check("to_stall_cycles", n, 5);
    check("to_req_cycles", nreq, 4);
    check("to_err", t_err, 1'b1);
    check("to_rdata", t_rdata, 32'h0);
    check("to_misalign", t_mis, 1'b0);
    @(negedge clock);
    check("to_idle_accepts", t_stall, 1'b1);
    check("to_idle_no_req", t_req, 1'b0);
    check("to_err_pulse", t_err, 1'b0);
    #1;
    t_read = 1'b0;

    repeat (10) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    check("bus_queue_drained", bus_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
